// File: rtl/sram_access_sequencer_pkg.sv
// Shared SRAM geometry and sequencer state encoding for the MEM-stage SRAM path.
package arm_mem_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_t;

endpackage

// File: rtl/sram_access_sequencer_if.sv
// Pipeline-side request/response and external SRAM bus signals of the MEM-stage sequencer.
interface sram_access_sequencer_if;
  import arm_mem_pkg::*;

  logic               mem_r_en;
  logic               mem_w_en;
  logic [31:0]        alu_res;
  logic [31:0]        val_rm;
  logic               ready;
  logic [31:0]        read_data;
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_dq_out;
  logic               sram_dq_oe;
  logic [SRAM_DW-1:0] sram_dq_in;
  logic               sram_we_n;
  logic               addr_err;

  modport slave (
    input  mem_r_en, mem_w_en, alu_res, val_rm, sram_dq_in,
    output ready, read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, addr_err
  );

  modport master (
    output mem_r_en, mem_w_en, alu_res, val_rm, sram_dq_in,
    input  ready, read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, addr_err
  );

endinterface

// File: rtl/sram_access_sequencer_wait_timer.sv
// Phase-length counter: last_cycle marks the final cycle of a WAIT_CYCLES+1 long half-word phase.
module sram_wait_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic last_cycle
);

  logic [2:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= 3'd0;
    end else if (load) begin
      count_reg <= 3'd0;
    end else if (tick) begin
      count_reg <= count_reg + 3'd1;
    end
  end

  assign last_cycle = (count_reg == 3'(WAIT_CYCLES));

endmodule

// File: rtl/sram_access_sequencer.sv
// Runs each 32-bit MEM-stage load/store as two 16-bit SRAM phases, holding ready low meanwhile.
// Optional out-of-range address trap enabled by defining SRAM_RANGE_CHECK_EN.
module sram_access_sequencer
  import arm_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input logic                    clk,
  input logic                    rst,
  sram_access_sequencer_if.slave bus
);

  sram_state_t        state_reg, state_next;
  logic               req;
  logic [16:0]        hw_idx;
  logic               timer_load, timer_tick, last_cycle;
  logic               is_write_reg;
  logic [15:0]        hi_data_reg;
  logic [31:0]        read_data_reg;
  logic [SRAM_AW-1:0] sram_addr_reg;
  logic [SRAM_DW-1:0] dq_out_reg;
  logic               dq_oe_reg;
  logic               we_n_reg;

  assign req    = bus.mem_r_en | bus.mem_w_en;
  assign hw_idx = 17'((bus.alu_res - BASE_ADDR) >> 2);

`ifdef SRAM_RANGE_CHECK_EN
  logic range_err;
  logic addr_err_reg;
  assign range_err    = (bus.alu_res < BASE_ADDR) || ((bus.alu_res - BASE_ADDR) >= 32'h0008_0000);
  assign bus.addr_err = addr_err_reg;
`else
  assign bus.addr_err = 1'b0;
`endif

  sram_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .tick       (timer_tick),
    .last_cycle (last_cycle)
  );

  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    timer_tick = 1'b0;
    case (state_reg)
      IDLE: if (req) begin
        timer_load = 1'b1;
        state_next = LO;
`ifdef SRAM_RANGE_CHECK_EN
        if (range_err) state_next = DONE;
`endif
      end
      LO: if (last_cycle) begin
        timer_load = 1'b1;
        state_next = HI;
      end else begin
        timer_tick = 1'b1;
      end
      HI: if (last_cycle) state_next = DONE;
          else            timer_tick = 1'b1;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are latched in IDLE so later input changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      is_write_reg  <= 1'b0;
      hi_data_reg   <= 16'd0;
      read_data_reg <= 32'd0;
      sram_addr_reg <= '0;
      dq_out_reg    <= '0;
      dq_oe_reg     <= 1'b0;
      we_n_reg      <= 1'b1;
`ifdef SRAM_RANGE_CHECK_EN
      addr_err_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (req) begin
`ifdef SRAM_RANGE_CHECK_EN
          if (range_err) begin
            addr_err_reg <= 1'b1;
            if (!bus.mem_w_en) read_data_reg <= 32'd0;
          end else
`endif
          begin
            sram_addr_reg <= {hw_idx, 1'b0};
            is_write_reg  <= bus.mem_w_en;
            hi_data_reg   <= bus.val_rm[31:16];
            if (bus.mem_w_en) begin
              dq_out_reg <= bus.val_rm[15:0];
              dq_oe_reg  <= 1'b1;
              we_n_reg   <= 1'b0;
            end
          end
        end
        LO: if (last_cycle) begin
          if (!is_write_reg) read_data_reg[15:0] <= bus.sram_dq_in;
          else               dq_out_reg          <= hi_data_reg;
          sram_addr_reg <= {sram_addr_reg[SRAM_AW-1:1], 1'b1};
        end
        HI: if (last_cycle) begin
          if (!is_write_reg) read_data_reg[31:16] <= bus.sram_dq_in;
          we_n_reg  <= 1'b1;
          dq_oe_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = (state_reg == DONE) || ((state_reg == IDLE) && !req);
  assign bus.read_data   = read_data_reg;
  assign bus.sram_addr   = sram_addr_reg;
  assign bus.sram_dq_out = dq_out_reg;
  assign bus.sram_dq_oe  = dq_oe_reg;
  assign bus.sram_we_n   = we_n_reg;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Scoreboard bench for sram_access_sequencer with a behavioural 16-bit SRAM; define SRAM_RANGE_CHECK_EN to cover the range trap.
module tb_sram_access_sequencer;
  import arm_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_access_sequencer_if bus();

  sram_access_sequencer #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural SRAM: combinational read, write sampled on the clock while we_n is low.
  logic [15:0] mem [0:262143];
  logic        pre_en = 1'b0;
  logic [17:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  assign bus.sram_dq_in = mem[bus.sram_addr];

  always @(posedge clk) begin
    if (pre_en)                        mem[pre_addr]      <= pre_data;
    else if (bus.sram_we_n === 1'b0)   mem[bus.sram_addr] <= bus.sram_dq_out;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] rd;
    int          start;
    int          lat;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: a completion is ready rising while out of reset.
  logic prev_ready = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && bus.ready === 1'b1 && prev_ready === 1'b0) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: completion at cycle %0d with empty scoreboard", cyc);
      end else begin
        e = q.pop_front();
        chk({e.name, "_latency"}, 32'(cyc - e.start), 32'(e.lat));
        chk({e.name, "_read_data"}, bus.read_data, e.rd);
        $display("txn %s: done at cycle %0d, latency %0d, read_data %h", e.name, cyc, cyc - e.start, bus.read_data);
      end
    end
    prev_ready <= bus.ready;
  end

  task automatic set_req(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.alu_res  = addr;
    bus.val_rm   = data;
  endtask

  task automatic issue(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data,
                       input string name, input logic [31:0] exp_rd, input int lat);
    set_req(r, w, addr, data);
    q.push_back('{name, exp_rd, cyc, lat});
  endtask

  task automatic wait_done(input string name, output int we_cnt);
    bit ok;
    ok = 0;
    we_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.sram_we_n === 1'b0) we_cnt++;
      if (bus.ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL %s_timeout: ready still %b after 40 cycles, required 1", name, bus.ready);
    end
  endtask

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wc;
    int bad;
    logic [17:0] addr_snap;
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",     32'(bus.ready),       32'd1);
    chk("reset_read_data", bus.read_data,        32'd0);
    chk("reset_sram_addr", 32'(bus.sram_addr),   32'd0);
    chk("reset_dq_out",    32'(bus.sram_dq_out), 32'd0);
    chk("reset_dq_oe",     32'(bus.sram_dq_oe),  32'd0);
    chk("reset_we_n",      32'(bus.sram_we_n),   32'd1);
    chk("reset_addr_err",  32'(bus.addr_err),    32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    bad = 0;
    addr_snap = bus.sram_addr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus.ready), 32'd1);
      if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0 || bus.sram_addr !== addr_snap) bad++;
    end
    chk("idle_bus_quiet", 32'(bad), 32'd0);
    @(posedge clk); #1;

    issue(1'b0, 1'b1, 32'd1024, 32'h1234_5678, "store_1024", 32'd0, 5);
    wait_done("store_1024", wc);
    chk("store_we_cycles", 32'(wc), 32'd4);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 32'd0, 32'd0);
    chk("store_mem0", 32'(mem[0]), 32'h0000_5678);
    chk("store_mem1", 32'(mem[1]), 32'h0000_1234);

    preload(18'd2, 16'hBEEF);
    preload(18'd3, 16'hCAFE);
    issue(1'b1, 1'b0, 32'd1028, 32'd0, "load_1028", 32'hCAFE_BEEF, 5);
    wait_done("load_1028", wc);
    chk("load_we_cycles", 32'(wc), 32'd0);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 32'd0, 32'd0);

    issue(1'b0, 1'b1, 32'd1040, 32'hDEAD_C0DE, "b2b_store", 32'hCAFE_BEEF, 5);
    wait_done("b2b_store", wc);
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'd1040, 32'd0, "b2b_load", 32'hDEAD_C0DE, 5);
    wait_done("b2b_load", wc);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 32'd0, 32'd0);

    issue(1'b1, 1'b1, 32'd1044, 32'h0BAD_F00D, "rw_both", 32'hDEAD_C0DE, 5);
    wait_done("rw_both", wc);
    chk("rw_both_we_cycles", 32'(wc), 32'd4);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 32'd0, 32'd0);
    chk("rw_both_mem10", 32'(mem[10]), 32'h0000_F00D);
    chk("rw_both_mem11", 32'(mem[11]), 32'h0000_0BAD);

    set_req(1'b0, 1'b1, 32'd1024, 32'hAAAA_5555);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 set_req(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("abort_we_n",      32'(bus.sram_we_n),  32'd1);
    chk("abort_dq_oe",     32'(bus.sram_dq_oe), 32'd0);
    chk("abort_idle",      32'(bus.ready),      32'd1);
    chk("abort_read_data", bus.read_data,       32'd0);
    chk("abort_sram_addr", 32'(bus.sram_addr),  32'd0);
    @(posedge clk); #1 rst = 1'b1;
    chk("abort_mem0", 32'(mem[0]), 32'h0000_5555);
    chk("abort_mem1", 32'(mem[1]), 32'h0000_1234);

    issue(1'b1, 1'b0, 32'd1024, 32'd0, "load_after_abort", 32'h1234_5555, 5);
    wait_done("load_after_abort", wc);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 32'd0, 32'd0);

`ifdef SRAM_RANGE_CHECK_EN
    issue(1'b1, 1'b0, 32'd512, 32'd0, "range_load_512", 32'd0, 1);
    wait_done("range_load_512", wc);
    chk("range_we_cycles", 32'(wc), 32'd0);
    chk("range_sram_addr", 32'(bus.sram_addr), 32'd1);
    chk("range_addr_err",  32'(bus.addr_err),  32'd1);
    @(posedge clk); #1 set_req(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("range_addr_err_sticky", 32'(bus.addr_err), 32'd1);
`else
    chk("no_range_addr_err", 32'(bus.addr_err), 32'd0);
`endif

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
